alu_dispatch_unit: RTL and testbench

- Issue/writeback stage placed directly upstream of the core ALU.
- Accepts one decoded-ready RV64 integer instruction plus its rs1/rs2 values over a valid/ready handshake.
- Builds the ALU's 17-bit op_code and operand pair, pulses the ALU trigger, and tracks the ALU's idle signal through busy and back to idle.
- Returns the result, tagged with rd, over a writeback valid/ready handshake; handles illegal encodings and ALU hangs itself.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_dispatch_unit_decoder.sv | 67 ++++++
 rtl/alu_dispatch_unit.sv | 181 ++++++++++++++++++
 tb/tb_alu_dispatch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch stage and the ALU itself.
// Opcode constants, 17-bit ALU encodings and the dispatch state type.
package alu_pkg;

  localparam int XLEN_DEFAULT         = 64;
  localparam int OPCODE_WIDTH_DEFAULT = 17;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [16:0] ADD_ENC  = 17'h00033;
  localparam logic [16:0] SUB_ENC  = 17'h10033;
  localparam logic [16:0] SLL_ENC  = 17'h000b3;
  localparam logic [16:0] SLT_ENC  = 17'h00133;
  localparam logic [16:0] XOR_ENC  = 17'h00233;
  localparam logic [16:0] SRL_ENC  = 17'h002b3;
  localparam logic [16:0] OR_ENC   = 17'h00333;
  localparam logic [16:0] AND_ENC  = 17'h003b3;
  localparam logic [16:0] MUL_ENC  = 17'h00433;
  localparam logic [16:0] ADDI_ENC = 17'h00013;
  localparam logic [16:0] SLLI_ENC = 17'h00093;
  localparam logic [16:0] SLTI_ENC = 17'h00113;
  localparam logic [16:0] XORI_ENC = 17'h00213;
  localparam logic [16:0] SRLI_ENC = 17'h00293;
  localparam logic [16:0] ORI_ENC  = 17'h00313;
  localparam logic [16:0] ANDI_ENC = 17'h00393;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_BUSY,
    WAIT_DONE,
    WB
  } dispatch_state_t;

endpackage

// File: rtl/alu_dispatch_unit_decoder.sv
// Combinational RV64 integer decode: instruction to ALU op_code,
// immediate operand and legality.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEFAULT
) (
  input  logic [31:0]             instr,
  output logic [OPCODE_WIDTH-1:0] op_code,
  output logic [XLEN-1:0]         imm,
  output logic                    use_imm,
  output logic                    legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_reg;
  logic       is_imm;
  logic       is_shift;
  logic       r_ext;
  logic       r_ok;
  logic       i_ok;
  logic       unused_fields;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_reg   = opcode == OP_REG;
  assign is_imm   = opcode == OP_IMM;
  assign is_shift = funct3 == 3'b001 || funct3 == 3'b101;

  // instr[30] selects SUB and instr[25] selects MUL; both need funct3 000
  assign r_ext = instr[30] | instr[25];
  assign r_ok  = !instr[31]
              && instr[29:26] == 4'b0000
              && !(instr[30] && instr[25])
              && (r_ext ? funct3 == 3'b000
                        : funct3 != 3'b011);
  assign i_ok  = is_shift ? instr[31:26] == 6'b000000
                          : funct3 != 3'b011;

  assign unused_fields = ^{instr[19:15], instr[11:7]};

  always_comb begin
    op_code = '0;
    imm     = '0;
    use_imm = 1'b0;
    legal   = 1'b0;
    unique case (1'b1)
      is_reg: begin
        op_code = OPCODE_WIDTH'({instr[30], 5'b0, instr[25],
                                 funct3, opcode});
        legal   = r_ok;
      end
      is_imm: begin
        op_code = OPCODE_WIDTH'({7'b0, funct3, opcode});
        use_imm = 1'b1;
        legal   = i_ok;
        imm     = is_shift
                ? {{(XLEN-6){1'b0}}, instr[25:20]}
                : {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_dispatch_unit.sv
// Issue/writeback stage in front of the core ALU: decodes, triggers,
// tracks idle/busy/idle and returns the tagged result.
module alu_dispatch_unit
  import alu_pkg::*;
#(
  parameter int              XLEN           = XLEN_DEFAULT,
  parameter int              OPCODE_WIDTH   = OPCODE_WIDTH_DEFAULT,
  parameter int              TRIG_CYCLES    = 2,
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter logic [XLEN-1:0] DEFAULT_DATA   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_rs1_val,
  input  logic [XLEN-1:0]         in_rs2_val,
  output logic [XLEN-1:0]         alu_operand_1,
  output logic [XLEN-1:0]         alu_operand_2,
  output logic [OPCODE_WIDTH-1:0] alu_op_code,
  output logic                    alu_trig,
  input  logic                    alu_idle,
  input  logic [XLEN-1:0]         alu_result,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic                    wb_illegal,
  output logic                    wb_timeout
);

  localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);

  dispatch_state_t state_q, state_d;

  logic [TRIG_W-1:0]       trig_cnt_q, trig_cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    seen_busy_q, seen_busy_d;
  logic [XLEN-1:0]         op1_q, op1_d;
  logic [XLEN-1:0]         op2_q, op2_d;
  logic [OPCODE_WIDTH-1:0] opc_q, opc_d;
  logic [4:0]              rd_q, rd_d;
  logic [XLEN-1:0]         data_q, data_d;
  logic                    illegal_q, illegal_d;
  logic                    timeout_q, timeout_d;

  logic [OPCODE_WIDTH-1:0] dec_opc;
  logic [XLEN-1:0]         dec_imm;
  logic                    dec_use_imm;
  logic                    dec_legal;
  logic                    active;
  logic                    tmo_hit;

  alu_op_decoder #(
    .XLEN         (XLEN),
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_dec (
    .instr   (in_instr),
    .op_code (dec_opc),
    .imm     (dec_imm),
    .use_imm (dec_use_imm),
    .legal   (dec_legal)
  );

  assign active  = state_q == TRIG
                || state_q == WAIT_BUSY
                || state_q == WAIT_DONE;
  assign tmo_hit = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d     = state_q;
    trig_cnt_d  = trig_cnt_q;
    tmo_d       = tmo_q;
    seen_busy_d = seen_busy_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    opc_d       = opc_q;
    rd_d        = rd_q;
    data_d      = data_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op1_d       = in_rs1_val;
          op2_d       = dec_use_imm ? dec_imm : in_rs2_val;
          opc_d       = dec_opc;
          rd_d        = in_instr[11:7];
          tmo_d       = '0;
          trig_cnt_d  = '0;
          seen_busy_d = 1'b0;
          if (dec_legal) begin
            state_d = TRIG;
          end else begin
            illegal_d = 1'b1;
            data_d    = DEFAULT_DATA;
            state_d   = WB;
          end
        end
      end
      TRIG: begin
        seen_busy_d = seen_busy_q | ~alu_idle;
        if (trig_cnt_q == TRIG_W'(TRIG_CYCLES - 1)) begin
          state_d = WAIT_BUSY;
        end else begin
          trig_cnt_d = trig_cnt_q + TRIG_W'(1);
        end
      end
      WAIT_BUSY: begin
        if (!alu_idle || seen_busy_q) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (alu_idle) begin
          data_d  = alu_result;
          state_d = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          state_d   = IDLE;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // a timeout overrides whatever progress the ALU made this cycle
    if (active) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_hit) begin
        state_d   = WB;
        timeout_d = 1'b1;
        data_d    = DEFAULT_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      trig_cnt_q  <= '0;
      tmo_q       <= '0;
      seen_busy_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      opc_q       <= '0;
      rd_q        <= '0;
      data_q      <= DEFAULT_DATA;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_cnt_q  <= trig_cnt_d;
      tmo_q       <= tmo_d;
      seen_busy_q <= seen_busy_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      opc_q       <= opc_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_ready      = state_q == IDLE;
  assign alu_trig      = state_q == TRIG;
  assign wb_valid      = state_q == WB;
  assign alu_operand_1 = op1_q;
  assign alu_operand_2 = op2_q;
  assign alu_op_code   = opc_q;
  assign wb_rd         = rd_q;
  assign wb_data       = data_q;
  assign wb_illegal    = illegal_q;
  assign wb_timeout    = timeout_q;

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Directed and random checks of alu_dispatch_unit against a
// mnemonic-level reference model and a behavioural ALU.
module tb_alu_dispatch_unit;

  localparam int TRIG    = 2;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1_val;
  logic [63:0] in_rs2_val;
  logic [63:0] alu_operand_1;
  logic [63:0] alu_operand_2;
  logic [16:0] alu_op_code;
  logic        alu_trig;
  logic        alu_idle = 1'b1;
  logic [63:0] alu_result = 64'h0;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_illegal;
  logic        wb_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  int alu_busy_len = 3;
  bit alu_hang     = 1'b0;
  int trig_total   = 0;
  int busy_cnt     = 0;
  bit trig_seen    = 1'b0;

  alu_dispatch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_rs1_val    (in_rs1_val),
    .in_rs2_val    (in_rs2_val),
    .alu_operand_1 (alu_operand_1),
    .alu_operand_2 (alu_operand_2),
    .alu_op_code   (alu_op_code),
    .alu_trig      (alu_trig),
    .alu_idle      (alu_idle),
    .alu_result    (alu_result),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_illegal    (wb_illegal),
    .wb_timeout    (wb_timeout)
  );

  always #5 clk = ~clk;

  // kinds: 0 add 1 sub 2 sll 3 slt 4 xor 5 srl 6 or 7 and 8 mul
  function automatic logic [63:0] alu_fn(input int k,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a << b[5:0];
      3: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4: return a ^ b;
      5: return a >> b[5:0];
      6: return a | b;
      7: return a & b;
      8: return a * b;
      default: return 64'h0;
    endcase
  endfunction

  // the ALU reads op_code fields as a real ALU would
  function automatic int alu_kind(input logic [16:0] opc);
    logic [2:0] f3;
    f3 = opc[9:7];
    if (opc[16]) return 1;
    if (opc[10]) return 8;
    case (f3)
      3'b000: return 0;
      3'b001: return 2;
      3'b010: return 3;
      3'b100: return 4;
      3'b101: return 5;
      3'b110: return 6;
      3'b111: return 7;
      default: return 0;
    endcase
  endfunction

  // ALU: first trig cycle starts a busy window of alu_busy_len cycles
  always @(negedge clk) begin
    if (alu_trig) trig_total++;
    if (alu_trig && !trig_seen) begin
      if (!alu_hang) begin
        alu_idle = 1'b0;
        busy_cnt = alu_busy_len;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        alu_idle   = 1'b1;
        alu_result = alu_fn(alu_kind(alu_op_code),
                            alu_operand_1, alu_operand_2);
      end
    end
    trig_seen = alu_trig;
  end

  // mnemonic-level reference: legality, encoding, operand 2, result
  function automatic void ref_decode(input logic [31:0] ins,
                                     input logic [63:0] a,
                                     input logic [63:0] b,
                                     output bit legal,
                                     output logic [16:0] opc,
                                     output logic [63:0] o2,
                                     output logic [63:0] res);
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [11:0] i12;
    int k;
    op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
    i12 = ins[31:20];
    legal = 1'b1; opc = 17'h0; o2 = b; k = 0;
    if (op == 7'h33) begin
      case ({f7, f3})
        {7'h00, 3'd0}: begin k = 0; opc = 17'h00033; end
        {7'h20, 3'd0}: begin k = 1; opc = 17'h10033; end
        {7'h00, 3'd1}: begin k = 2; opc = 17'h000b3; end
        {7'h00, 3'd2}: begin k = 3; opc = 17'h00133; end
        {7'h00, 3'd4}: begin k = 4; opc = 17'h00233; end
        {7'h00, 3'd5}: begin k = 5; opc = 17'h002b3; end
        {7'h00, 3'd6}: begin k = 6; opc = 17'h00333; end
        {7'h00, 3'd7}: begin k = 7; opc = 17'h003b3; end
        {7'h01, 3'd0}: begin k = 8; opc = 17'h00433; end
        default: legal = 1'b0;
      endcase
    end else if (op == 7'h13) begin
      o2 = {{52{i12[11]}}, i12};
      case (f3)
        3'd0: begin k = 0; opc = 17'h00013; end
        3'd2: begin k = 3; opc = 17'h00113; end
        3'd4: begin k = 4; opc = 17'h00213; end
        3'd6: begin k = 6; opc = 17'h00313; end
        3'd7: begin k = 7; opc = 17'h00393; end
        3'd1: begin k = 2; opc = 17'h00093; end
        3'd5: begin k = 5; opc = 17'h00293; end
        default: legal = 1'b0;
      endcase
      if (f3 == 3'd1 || f3 == 3'd5) begin
        o2 = {58'h0, ins[25:20]};
        if (ins[31:26] != 6'h0) legal = 1'b0;
      end
    end else begin
      legal = 1'b0;
    end
    res = alu_fn(k, a, o2);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] ins,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     input int busy,
                     input bit hang,
                     input int hold);
    bit          legal;
    bit          steady;
    logic [16:0] opc;
    logic [63:0] o2;
    logic [63:0] res;
    logic [63:0] exp_data;
    int          n;
    int          exp_lat;
    int          t0;
    ref_decode(ins, a, b, legal, opc, o2, res);
    exp_data = (!legal || hang) ? 64'h0 : res;
    if (!legal) exp_lat = 0;
    else if (hang) exp_lat = TIMEOUT;
    else exp_lat = (busy + 1 > TRIG + 2) ? busy + 1 : TRIG + 2;
    alu_busy_len = busy;
    alu_hang     = hang;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    t0 = trig_total;
    in_valid = 1'b1; in_instr = ins;
    in_rs1_val = a; in_rs2_val = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = $urandom;
    in_rs1_val = {$urandom, $urandom};
    in_rs2_val = {$urandom, $urandom};
    if (legal) begin
      chk("op_code", alu_op_code, opc);
      chk("operand_1", alu_operand_1, a);
      chk("operand_2", alu_operand_2, o2);
    end
    n = 0; steady = 1'b1;
    while (!wb_valid && n < 4000) begin
      if (in_ready !== 1'b0) steady = 1'b0;
      if (legal && (alu_op_code !== opc
                    || alu_operand_1 !== a
                    || alu_operand_2 !== o2)) steady = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("in_flight_stable", steady, 1);
    chk("wb_rd", wb_rd, ins[11:7]);
    chk("wb_data", wb_data, exp_data);
    chk("wb_illegal", wb_illegal, !legal);
    chk("wb_timeout", wb_timeout, legal && hang);
    steady = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_data !== exp_data
          || wb_rd !== ins[11:7] || in_ready !== 1'b0)
        steady = 1'b0;
    end
    if (hold > 0) chk("wb_hold", steady, 1);
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_ready = 1'b0;
    chk("wb_released", wb_valid, 0);
    chk("idle_after_wb", in_ready, 1);
    chk("trig_cycles", trig_total - t0, legal ? TRIG : 0);
  endtask

  initial begin
    bit          seen_wb;
    logic [31:0] ins;
    logic [6:0]  f7;
    int          r;
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
    in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_alu_trig", alu_trig, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flags", {wb_illegal, wb_timeout}, 0);
    chk("rst_operands", alu_operand_1 | alu_operand_2, 0);
    chk("rst_op_code", alu_op_code, 0);
    rst = 1'b0;

    // ADD x3,x1,x2 with a 10-cycle writeback stall
    run({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 64'd5, 64'd7, 3, 0, 10);
    // SUB x4,x1,x2
    run({7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33}, 64'd3, 64'd5, 3, 0, 0);
    // ADDI x5,x1,-1
    run({12'hfff, 5'd1, 3'd0, 5'd5, 7'h13}, 64'd0, 64'd9, 2, 0, 1);
    // SRAI is not supported
    run({6'b010000, 6'd3, 5'd1, 3'd5, 5'd6, 7'h13}, 64'd8, 64'd0, 3, 0, 2);
    // SLTU is not supported
    run({7'h00, 5'd2, 5'd1, 3'd3, 5'd8, 7'h33}, 64'd1, 64'd2, 3, 0, 0);
    // ALU never goes busy
    run({7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33}, 64'd1, 64'd2, 3, 1, 0);
    // MUL right after the timeout, rd = x0
    run({7'h01, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33}, 64'd6, 64'd7, 5, 0, 0);

    // reset while waiting for a slow ALU
    alu_busy_len = 20; alu_hang = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {7'h00, 5'd2, 5'd1, 3'd6, 5'd9, 7'h33};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_alu_trig", alu_trig, 0);
    chk("abort_op_code", alu_op_code, 0);
    seen_wb = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) seen_wb = 1'b1;
    end
    chk("abort_no_wb", seen_wb, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      ins = $urandom;
      if (r < 4) begin
        case ($urandom_range(0, 5))
          0: f7 = 7'h20;
          1: f7 = 7'h01;
          2: f7 = 7'($urandom);
          default: f7 = 7'h00;
        endcase
        ins = {f7, ins[24:7], 7'h33};
      end else if (r < 8) begin
        ins[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) ins[31:26] = 6'h0;
      end
      run(ins, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(1, 6), 0, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
